i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning SCL period in clock cycles; even and >= 4.
REQ-002 SHALL have port clock, input, 1, the single clock; all flops on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port enable, input, 1; when low, the block is held in IDLE with both lines released.
REQ-005 SHALL have port start, input, 1, one-cycle command pulse; accepted only in IDLE.
REQ-006 SHALL have port address, input, 7, target address, captured on start.
REQ-007 SHALL have port read_write_flag, input, 1; 1 = read from slave, 0 = write; captured on start.
REQ-008 SHALL have port byte_number, input, 8, bytes to transfer; captured on start; 0 means address phase only.
REQ-009 SHALL have port data_write, input, 8, next byte to send; sampled when data_request pulses.
REQ-010 SHALL have port data_read, output, 8, last byte received.
REQ-011 SHALL have port data_request, output, 1, one-cycle pulse; data_write is captured in the same cycle.
REQ-012 SHALL have port data_finish, output, 1, one-cycle pulse after each data byte's ACK bit completes.
REQ-013 SHALL have port transfer_status, output, 1; high from start acceptance until STOP completes.
REQ-014 SHALL have port error, output, 1, sticky NACK flag; cleared on the next accepted start.
REQ-015 SHALL have ports scl_in, sda_in (input, 1) and scl_out, sda_out (output, 1), open-drain: 1 = release, 0 = drive low.

Function
REQ-016 SHALL use states IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
REQ-017 SHALL split each SCL bit period into a low half and a high half of CLK_DIV/2 cycles each.
REQ-018 SHALL change sda_out only in the first cycle of a low half.
REQ-019 SHALL sample sda_in in the first cycle of a high half in which scl_in=1.
REQ-020 SHALL freeze the phase counter (clock stretching) while scl_out=1 and scl_in=0.
REQ-021 START: with scl_out=1, SHALL drive sda_out=0, hold it for CLK_DIV/2 cycles, then drive scl_out=0.
REQ-022 ADDR: SHALL shift {address, read_write_flag} MSB first over 8 bit periods.
REQ-023 ADDR_ACK: SHALL release SDA and sample it.
REQ-024 If the sampled ADDR_ACK value is 1 (NACK), SHALL set error and go to STOP.
REQ-025 If ADDR_ACK is 0 (ACK): SHALL go to STOP when byte_number=0, to RD_BYTE when reading, and otherwise pulse data_request and go to WR_BYTE.
REQ-026 WR_BYTE: SHALL send the captured byte MSB first; WR_ACK then releases SDA and samples it.
REQ-027 After WR_ACK, SHALL pulse data_finish.
REQ-028 A WR_ACK NACK SHALL set error and go to STOP.
REQ-029 A WR_ACK ACK with bytes remaining SHALL pulse data_request and return to WR_BYTE; otherwise SHALL go to STOP.
REQ-030 RD_BYTE: SHALL release SDA and shift 8 samples MSB first; data_read is updated at the end of the 8th bit.
REQ-031 RD_ACK: SHALL drive 0 (ACK) if bytes remain and release (NACK) on the last byte, then pulse data_finish.
REQ-032 STOP: SHALL drive sda_out=0 in the low half, then scl_out=1, then sda_out=1 after CLK_DIV/2 cycles, then return to IDLE.
REQ-033 transfer_status SHALL drop in the cycle IDLE is re-entered.
REQ-034 The remaining-byte counter SHALL decrement once per data byte and never wrap below 0.
REQ-035 start SHALL be ignored while transfer_status=1 or enable=0.
REQ-036 Deassertion of enable mid-transfer SHALL NOT abort; the block SHALL complete through STOP and then remain in IDLE.

Reset
REQ-037 While reset_n=0: state=IDLE; scl_out=1; sda_out=1; data_read=8'h00; data_request=0; data_finish=0; transfer_status=0; error=0; counters=0.
REQ-038 Reset asserted mid-transfer SHALL release both lines immediately and SHALL NOT generate a STOP.

Verification
REQ-039 Write, address 7'h5D, byte_number=2, data 8'h13 then 8'h57, slave ACKs all -> SDA bytes 8'hBA, 8'h13, 8'h57; 2 data_request pulses; 2 data_finish pulses; error=0; STOP seen.
REQ-040 Address 7'h64 with no responder (SDA released in ACK) -> error=1 after ADDR_ACK; STOP follows; no data_request pulse; transfer_status returns to 0.
REQ-041 Read, address 7'h5D, byte_number=2, slave returns 8'h9B then 8'hDF -> SDA address byte 8'hBB; data_read=8'h9B then 8'hDF; master ACK after byte 1, NACK after byte 2.
REQ-042 Slave holds scl_in low 10 cycles during WR_BYTE bit 3 -> phase frozen; transmitted byte unchanged; total transfer lengthened by exactly 10 cycles.
REQ-043 reset_n pulsed low during the second data byte -> scl_out=sda_out=1 immediately; all outputs at reset values; a new start is then accepted normally.
REQ-044 start pulsed while transfer_status=1 -> ignored; address and byte count of the running transfer unchanged.

Source files
------------

// File: rtl/i2c_master.sv
// Single-master I2C controller: START, 7-bit address, N data bytes, STOP.
// Open-drain pins (1 = release), SCL stretching honoured in the high half.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       start,
  input  logic [6:0] address,
  input  logic       read_write_flag,
  input  logic [7:0] byte_number,
  input  logic [7:0] data_write,
  output logic [7:0] data_read,
  output logic       data_request,
  output logic       data_finish,
  output logic       transfer_status,
  output logic       error,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);

  localparam logic [CW-1:0] C_HL  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_HH  = CW'(HALF);
  localparam logic [CW-1:0] C_RQ  = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] C_END = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    STOP
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  tx_buf;
  logic [7:0]  rx;
  logic [7:0]  remaining;
  logic        rw_r;
  logic        ack_r;

  logic        stall;
  logic        ack_now;
  logic        more;
  logic [7:0]  dec;
  logic [7:0]  wr_byte;

  assign stall   = scl_out & ~scl_in;
  assign ack_now = (cnt == C_HH) ? sda_in : ack_r;
  assign more    = remaining > 8'd1;
  assign dec     = (remaining == 8'd0) ? 8'd0
                                       : remaining - 8'd1;
  // data_write is valid in the data_request cycle itself
  assign wr_byte = data_request ? data_write : tx_buf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      tx_buf          <= '0;
      rx              <= '0;
      remaining       <= '0;
      rw_r            <= 1'b0;
      ack_r           <= 1'b0;
      scl_out         <= 1'b1;
      sda_out         <= 1'b1;
      data_read       <= '0;
      data_request    <= 1'b0;
      data_finish     <= 1'b0;
      transfer_status <= 1'b0;
      error           <= 1'b0;
    end else begin
      data_request <= 1'b0;
      data_finish  <= 1'b0;
      if (data_request) tx_buf <= data_write;
      if (state == IDLE) begin
        scl_out <= 1'b1;
        sda_out <= 1'b1;
        cnt     <= '0;
        if (start && enable) begin
          state           <= START;
          transfer_status <= 1'b1;
          error           <= 1'b0;
          shreg           <= {address, read_write_flag};
          rw_r            <= read_write_flag;
          remaining       <= byte_number;
          sda_out         <= 1'b0;
        end
      end else if (!stall) begin
        cnt <= cnt + 1'b1;
        if (state == START) begin
          if (cnt == C_HL) begin
            state   <= ADDR;
            cnt     <= '0;
            scl_out <= 1'b0;
            sda_out <= shreg[7];
            bit_idx <= 3'd7;
          end
        end else begin
          if (cnt == C_HL) scl_out <= 1'b1;
          if (cnt == C_HH) begin
            ack_r <= sda_in;
            if (state == RD_BYTE) rx <= {rx[6:0], sda_in};
          end
          if (cnt == C_RQ && !ack_now &&
              ((state == ADDR_ACK && !rw_r &&
                remaining != 8'd0) ||
               (state == WR_ACK && more)))
            data_request <= 1'b1;
          if (cnt == C_END) begin
            cnt <= '0;
            if (state == STOP) begin
              state           <= IDLE;
              sda_out         <= 1'b1;
              transfer_status <= 1'b0;
            end else begin
              scl_out <= 1'b0;
              unique case (state)
                ADDR, WR_BYTE: begin
                  if (bit_idx != 3'd0) begin
                    bit_idx <= bit_idx - 3'd1;
                    sda_out <= shreg[bit_idx - 3'd1];
                  end else begin
                    state   <= (state == ADDR) ? ADDR_ACK
                                               : WR_ACK;
                    sda_out <= 1'b1;
                  end
                end
                ADDR_ACK, WR_ACK: begin
                  if (state == WR_ACK) begin
                    data_finish <= 1'b1;
                    remaining   <= dec;
                  end
                  if (ack_r) begin
                    error   <= 1'b1;
                    state   <= STOP;
                    sda_out <= 1'b0;
                  end else if (state == ADDR_ACK &&
                               remaining == 8'd0) begin
                    state   <= STOP;
                    sda_out <= 1'b0;
                  end else if (state == ADDR_ACK && rw_r) begin
                    state   <= RD_BYTE;
                    sda_out <= 1'b1;
                    bit_idx <= 3'd7;
                  end else if (state == ADDR_ACK || more) begin
                    state   <= WR_BYTE;
                    shreg   <= wr_byte;
                    sda_out <= wr_byte[7];
                    bit_idx <= 3'd7;
                  end else begin
                    state   <= STOP;
                    sda_out <= 1'b0;
                  end
                end
                RD_BYTE: begin
                  if (bit_idx != 3'd0) begin
                    bit_idx <= bit_idx - 3'd1;
                  end else begin
                    data_read <= rx;
                    state     <= RD_ACK;
                    sda_out   <= ~more;
                  end
                end
                RD_ACK: begin
                  data_finish <= 1'b1;
                  remaining   <= dec;
                  if (more) begin
                    state   <= RD_BYTE;
                    sda_out <= 1'b1;
                    bit_idx <= 3'd7;
                  end else begin
                    state   <= STOP;
                    sda_out <= 1'b0;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: bus-level slave model,
// expected frames/bytes/transfer summaries queued by stimulus.
module tb_i2c_master;

  localparam int D = 4;
  localparam int H = D / 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [6:0] address = '0;
  logic       read_write_flag = 1'b0;
  logic [7:0] byte_number = '0;
  logic [7:0] data_write = '0;
  logic [7:0] data_read;
  logic       data_request, data_finish;
  logic       transfer_status, error;
  logic       scl_in, sda_in, scl_out, sda_out;
  logic       slave_sda = 1'b1;
  logic       stretch = 1'b0;

  assign scl_in = scl_out & ~stretch;
  assign sda_in = sda_out & slave_sda;

  i2c_master #(.CLK_DIV(D)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .start(start), .address(address),
    .read_write_flag(read_write_flag),
    .byte_number(byte_number), .data_write(data_write),
    .data_read(data_read), .data_request(data_request),
    .data_finish(data_finish),
    .transfer_status(transfer_status), .error(error),
    .scl_in(scl_in), .sda_in(sda_in),
    .scl_out(scl_out), .sda_out(sda_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic err;
    int   nreq;
    int   nfin;
    int   len;
  } txn_t;

  typedef struct packed {
    logic       rd;
    logic [7:0] val;
  } fin_t;

  txn_t       exp_txn[$];
  logic [8:0] exp_frame[$];
  fin_t       exp_fin[$];
  logic [7:0] wr_data_q[$];

  // slave configuration for the current transfer
  logic       sl_present = 1'b1;
  logic       sl_rw = 1'b0;
  int         sl_nb = 0;
  int         sl_nack_at = 0;
  logic       stretch_en = 1'b0;
  logic [7:0] sl_rd [0:15];
  logic       done = 1'b0;

  int         checks = 0;
  int         errors = 0;

  // ---------------- monitor / slave / scoreboard ----------------
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       prev_ts = 1'b0, in_rst = 1'b0;
  logic       stretch_used = 1'b0;
  logic [8:0] frame = '0;
  logic [8:0] ef;
  logic [7:0] tmp;
  int         bits = 0, nfall = 0, scnt = 0, stops = 0;
  int         req_n = 0, fin_n = 0, len = 0;
  int         g, f, b;
  txn_t       t;
  fin_t       fe;

  task automatic chk(input string nm, input int got,
                     input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  always begin
    @(negedge clock or negedge reset_n);
    #1;
    if (done) begin
      chk("queues_drained",
          exp_txn.size() + exp_frame.size() +
          exp_fin.size() + wr_data_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
    end
    if (!reset_n) begin
      if (!in_rst) begin
        in_rst = 1'b1;
        chk("rst_scl_out", int'(scl_out), 1);
        chk("rst_sda_out", int'(sda_out), 1);
        chk("rst_data_read", int'(data_read), 0);
        chk("rst_data_request", int'(data_request), 0);
        chk("rst_data_finish", int'(data_finish), 0);
        chk("rst_transfer_status", int'(transfer_status), 0);
        chk("rst_error", int'(error), 0);
      end
      exp_txn.delete();
      exp_frame.delete();
      exp_fin.delete();
      wr_data_q.delete();
      bits = 0; nfall = 0; stops = 0;
      req_n = 0; fin_n = 0; len = 0;
      slave_sda = 1'b1; stretch = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1; prev_ts = 1'b0;
    end else begin
      in_rst = 1'b0;
      if (prev_scl && scl_out && prev_sda && !sda_in) begin
        bits = 0; nfall = 0; stretch_used = 1'b0;
      end
      if (prev_scl && scl_out && !prev_sda && sda_in) begin
        stops++; bits = 0;
      end
      if (!prev_scl && scl_out) begin
        frame = {frame[7:0], sda_in};
        bits++;
        if (bits == 9) begin
          bits = 0;
          checks++;
          if (exp_frame.size() == 0) begin
            errors++;
            $display("FAIL frame: got %03h required none", frame);
          end else begin
            ef = exp_frame.pop_front();
            if (frame != ef) begin
              errors++;
              $display("FAIL frame: got %03h required %03h",
                       frame, ef);
            end
          end
        end
        if (stretch_en && !stretch_used && nfall - 1 == 12) begin
          stretch = 1'b1; scnt = 10; stretch_used = 1'b1;
        end
      end else if (stretch) begin
        scnt--;
        if (scnt == 0) stretch = 1'b0;
      end
      if (prev_scl && !scl_out) begin
        nfall++;
        g = nfall - 1; f = g / 9; b = g % 9;
        slave_sda = 1'b1;
        if (f == 0) begin
          if (b == 8 && sl_present) slave_sda = 1'b0;
        end else if (sl_present && f <= sl_nb) begin
          if (sl_rw) begin
            tmp = sl_rd[f-1];
            if (b < 8) slave_sda = tmp[7-b];
          end else if (b == 8) begin
            slave_sda = (f == sl_nack_at);
          end
        end
      end
      if (data_request) begin
        req_n++;
        checks++;
        if (wr_data_q.size() == 0) begin
          errors++;
          $display("FAIL data_request: got pulse required none");
        end else data_write = wr_data_q.pop_front();
      end
      if (data_finish) begin
        fin_n++;
        checks++;
        if (exp_fin.size() == 0) begin
          errors++;
          $display("FAIL data_finish: got pulse required none");
        end else begin
          fe = exp_fin.pop_front();
          if (fe.rd && data_read != fe.val) begin
            errors++;
            $display("FAIL data_read: got %02h required %02h",
                     data_read, fe.val);
          end
        end
      end
      if (transfer_status) begin
        len++;
        if (len == 3000) chk("watchdog", len, 0);
      end
      if (prev_ts && !transfer_status) begin
        if (exp_txn.size() == 0) begin
          chk("unexpected_transfer", 1, 0);
        end else begin
          t = exp_txn.pop_front();
          chk("error_flag", int'(error), int'(t.err));
          chk("length", len, t.len);
          chk("requests", req_n, t.nreq);
          chk("finishes", fin_n, t.nfin);
          chk("stop_seen", stops, 1);
        end
        len = 0; req_n = 0; fin_n = 0; stops = 0;
      end
      prev_scl = scl_out;
      prev_sda = sda_in;
      prev_ts  = transfer_status;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic prep(input logic [6:0] a, input logic rw,
                      input int nb, input logic present,
                      input int nack_at, input logic st,
                      input logic fixed, input logic [15:0] fb);
    txn_t       tt;
    int         k;
    logic [7:0] d;
    logic       ack;
    sl_present = present; sl_rw = rw; sl_nb = nb;
    sl_nack_at = nack_at; stretch_en = st;
    k = 0;
    exp_frame.push_back({a, rw, ~present});
    if (present) begin
      for (int i = 0; i < nb; i++) begin
        if (fixed && i < 2) d = (i == 0) ? fb[15:8] : fb[7:0];
        else d = 8'($urandom);
        if (rw) begin
          sl_rd[i] = d;
          ack = (i == nb - 1);
        end else begin
          wr_data_q.push_back(d);
          ack = (i + 1 == nack_at);
        end
        exp_frame.push_back({d, ack});
        exp_fin.push_back({rw, d});
        k = i + 1;
        if (!rw && ack) break;
      end
    end
    tt.err  = !present ||
              (!rw && nack_at >= 1 && nack_at <= nb);
    tt.nreq = rw ? 0 : k;
    tt.nfin = k;
    tt.len  = H + D * (9 * (1 + k) + 1) +
              ((st && k >= 1) ? 10 : 0);
    exp_txn.push_back(tt);
  endtask

  task automatic go(input logic [6:0] a, input logic rw,
                    input int nb);
    tick();
    address = a; read_write_flag = rw;
    byte_number = 8'(nb); start = 1'b1;
    tick();
    start = 1'b0;
    address = 7'($urandom);
    read_write_flag = 1'($urandom);
    byte_number = 8'($urandom);
  endtask

  task automatic finish_wait();
    for (int i = 0; i < 5000; i++) begin
      if (!transfer_status) break;
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic run(input logic [6:0] a, input logic rw,
                     input int nb, input logic present,
                     input int nack_at, input logic st,
                     input logic busy, input logic drop,
                     input logic fixed, input logic [15:0] fb);
    prep(a, rw, nb, present, nack_at, st, fixed, fb);
    go(a, rw, nb);
    if (busy) begin
      repeat (20) tick();
      address = ~a; byte_number = 8'(nb + 5);
      read_write_flag = ~rw; start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (drop) begin
      repeat (10) tick();
      enable = 1'b0;
    end
    finish_wait();
    if (drop) begin
      address = 7'h11; byte_number = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      enable = 1'b1;
      repeat (2) tick();
    end
  endtask

  initial begin
    int nb, nk, nr;
    logic rw, pr, st;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    run(7'h5D, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0,
        1'b1, 16'h1357);
    run(7'h64, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0,
        1'b0, 16'h0);
    run(7'h5D, 1'b1, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0,
        1'b1, 16'h9BDF);
    run(7'h5D, 1'b0, 2, 1'b1, 0, 1'b1, 1'b0, 1'b0,
        1'b1, 16'hA55A);
    run(7'h2A, 1'b0, 1, 1'b1, 0, 1'b0, 1'b1, 1'b0,
        1'b0, 16'h0);
    run(7'h33, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0, 1'b1,
        1'b0, 16'h0);
    run(7'h41, 1'b0, 3, 1'b1, 2, 1'b0, 1'b0, 1'b0,
        1'b0, 16'h0);
    run(7'h7F, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0,
        1'b0, 16'h0);
    run(7'h01, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0,
        1'b0, 16'h0);
    // reset in the middle of the second data byte
    prep(7'h5D, 1'b0, 3, 1'b1, 0, 1'b0, 1'b0, 16'h0);
    go(7'h5D, 1'b0, 3);
    nr = 0;
    for (int i = 0; i < 2000 && nr < 2; i++) begin
      tick();
      if (data_request) nr++;
    end
    repeat (8) tick();
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    run(7'h5D, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0,
        1'b1, 16'h1357);
    for (int n = 0; n < 14; n++) begin
      rw = 1'($urandom);
      nb = $urandom_range(0, 3);
      pr = ($urandom_range(0, 9) != 0);
      nk = (!rw && $urandom_range(0, 3) == 0)
           ? $urandom_range(1, 3) : 0;
      st = !rw && nb > 0 && ($urandom_range(0, 2) == 0);
      run(7'($urandom), rw, nb, pr, nk, st, 1'b0, 1'b0,
          1'b0, 16'h0);
    end
    done = 1'b1;
    repeat (10) tick();
    $display("FAIL monitor: got no summary required summary");
    $fatal(1);
  end

endmodule
